// File: rtl/mux_41_rr_if.sv
// Bundle of the 4-channel merge bus: four producer channels in, one consumer stream out.
// The master modport is the producer/consumer side, the slave modport is the arbiter.
interface mux_41_rr_if #(
  parameter int DW = 8
);
  logic [4*DW-1:0] din;
  logic [3:0]      din_valid;
  logic [3:0]      din_ready;
  logic [DW-1:0]   dout;
  logic            dout_valid;
  logic            dout_ready;
  logic [1:0]      sel;

  modport master (
    output din, din_valid, dout_ready,
    input  din_ready, dout, dout_valid, sel
  );

  modport slave (
    input  din, din_valid, dout_ready,
    output din_ready, dout, dout_valid, sel
  );
endinterface

// File: rtl/mux_41_rr.sv
// mux_41_rr: 4:1 stream merge with round-robin arbitration and a registered
// 1-entry output stage. dout carries the winning beat, sel its channel index.
// Build option: define FIXED_PRIO_EN for fixed priority (ch0 > ch1 > ch2 > ch3);
// the round-robin pointer is then removed. Default (undefined) is round-robin.
module mux_41_rr #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mux_41_rr_if.slave    bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        state_p1;
  logic [DW-1:0] dout_p1;
  logic [1:0]    sel_p1;
  logic          vld_p1;

  logic [1:0]    start_p0;
  logic          gnt_any_p0;
  logic [1:0]    gnt_idx_p0;
  logic          load_en_p0;
  logic          take_p0;
  logic [DW-1:0] win_data_p0;

  // Circular first-set search over v, beginning at channel s.
  // Walking k downwards lets the nearest hit (smallest k) overwrite the others.
  function automatic logic [2:0] rr_pick(input logic [3:0] v, input logic [1:0] s);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = s + 2'(k);
      if (v[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef FIXED_PRIO_EN
  assign start_p0 = 2'd0;
`else
  logic [1:0] ptr_p1;
  assign start_p0 = ptr_p1;
`endif

  // Grant selection, load enable and per-channel ready; ready is forced low during reset.
  always_comb begin
    {gnt_any_p0, gnt_idx_p0} = rr_pick(bus.din_valid, start_p0);
    load_en_p0  = ~vld_p1 | bus.dout_ready;
    take_p0     = load_en_p0 & gnt_any_p0 & rst_n;
    win_data_p0 = bus.din[DW*gnt_idx_p0 +: DW];
    bus.din_ready = take_p0 ? (4'b0001 << gnt_idx_p0) : 4'b0000;
  end

  // ---- p0 -> p1: output-stage FSM with registered dout/sel/valid ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p1 <= EMPTY;
      vld_p1   <= 1'b0;
      dout_p1  <= '0;
      sel_p1   <= 2'd0;
`ifndef FIXED_PRIO_EN
      ptr_p1   <= 2'd0;
`endif
    end else begin
      case (state_p1)
        EMPTY: begin
          if (gnt_any_p0) begin
            state_p1 <= FULL;
            vld_p1   <= 1'b1;
            dout_p1  <= win_data_p0;
            sel_p1   <= gnt_idx_p0;
`ifndef FIXED_PRIO_EN
            ptr_p1   <= gnt_idx_p0 + 2'd1;
`endif
          end
        end
        FULL: begin
          if (bus.dout_ready) begin
            if (gnt_any_p0) begin
              dout_p1 <= win_data_p0;
              sel_p1  <= gnt_idx_p0;
`ifndef FIXED_PRIO_EN
              ptr_p1  <= gnt_idx_p0 + 2'd1;
`endif
            end else begin
              state_p1 <= EMPTY;
              vld_p1   <= 1'b0;
            end
          end
        end
        default: begin
          state_p1 <= EMPTY;
          vld_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.sel        = sel_p1;
  assign bus.dout_valid = vld_p1;

endmodule
